timer_digit_formatter: RTL and testbench

- Consumer of the round countdown value: takes the 8-bit seconds-remaining count and converts it to M:SS decimal digits for the HUD/seven-segment driver.
- Conversion is iterative, using repeated subtraction by 60 and then by 10, so no dividers are needed.
- Also generates the low-time warning, the blink gate for the digits, and the time-up flag used by the game-state logic.

---
 rtl/timer_digit_formatter.sv | 174 +++++++++++++++++
 tb/tb_timer_digit_formatter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/timer_digit_formatter.sv
// Converts an 8-bit seconds count to M:SS digits by repeated subtraction,
// and derives the low-time warning, the blink gate and the time-up flag.
module timer_digit_formatter #(
    parameter logic [7:0]  LOW_THRESH = 8'd30,
    parameter logic [23:0] BLINK_HALF = 24'd5000000
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic [7:0] seconds_in_i,
    input  logic       force_update_i,
    output logic [3:0] minutes_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic       digits_valid_o,
    output logic       update_pulse_o,
    output logic       busy_o,
    output logic       low_time_o,
    output logic       time_up_o,
    output logic       display_on_o
);

    // state  | meaning
    // IDLE   | waiting for a new value, a force request or the first conversion
    // MIN    | subtracting 60 per cycle, counting minutes
    // TEN    | subtracting 10 per cycle, counting tens of seconds
    // LOAD   | publishing digits and flags
    typedef enum logic [1:0] {S_IDLE, S_MIN, S_TEN, S_LOAD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  work_q, work_d;
    logic [7:0]  last_val_q, last_val_d;
    logic [2:0]  min_acc_q, min_acc_d;
    logic [2:0]  tens_acc_q, tens_acc_d;
    logic        first_q, first_d;
    logic [3:0]  minutes_q, minutes_d;
    logic [3:0]  sec_tens_q, sec_tens_d;
    logic [3:0]  sec_ones_q, sec_ones_d;
    logic        digits_valid_q, digits_valid_d;
    logic        update_pulse_q, update_pulse_d;
    logic        low_time_q, low_time_d;
    logic        time_up_q, time_up_d;
    logic [23:0] blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d;
    logic        start;

    assign start = first_q || (seconds_in_i != last_val_q) || force_update_i;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_MIN;
            S_MIN:  if (work_q < 8'd60) state_d = S_TEN;
            S_TEN:  if (work_q < 8'd10) state_d = S_LOAD;
            S_LOAD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o         = (state_q != S_IDLE);
        minutes_o      = minutes_q;
        sec_tens_o     = sec_tens_q;
        sec_ones_o     = sec_ones_q;
        digits_valid_o = digits_valid_q;
        update_pulse_o = update_pulse_q;
        low_time_o     = low_time_q;
        time_up_o      = time_up_q;
        display_on_o   = low_time_q ? phase_q : 1'b1;
    end

    always_comb begin
        work_d         = work_q;
        last_val_d     = last_val_q;
        min_acc_d      = min_acc_q;
        tens_acc_d     = tens_acc_q;
        first_d        = first_q;
        minutes_d      = minutes_q;
        sec_tens_d     = sec_tens_q;
        sec_ones_d     = sec_ones_q;
        digits_valid_d = digits_valid_q;
        update_pulse_d = 1'b0;
        low_time_d     = low_time_q;
        time_up_d      = time_up_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d     = seconds_in_i;
                    last_val_d = seconds_in_i;
                    min_acc_d  = 3'd0;
                    tens_acc_d = 3'd0;
                    first_d    = 1'b0;
                end
            end
            S_MIN: begin
                if (work_q >= 8'd60) begin
                    work_d    = work_q - 8'd60;
                    min_acc_d = min_acc_q + 3'd1;
                end
            end
            S_TEN: begin
                if (work_q >= 8'd10) begin
                    work_d     = work_q - 8'd10;
                    tens_acc_d = tens_acc_q + 3'd1;
                end
            end
            S_LOAD: begin
                minutes_d      = {1'b0, min_acc_q};
                sec_tens_d     = {1'b0, tens_acc_q};
                sec_ones_d     = work_q[3:0];
                time_up_d      = (last_val_q == 8'd0);
                low_time_d     = (last_val_q != 8'd0) && (last_val_q <= LOW_THRESH);
                digits_valid_d = 1'b1;
                update_pulse_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Restart the blink on the warning's rising edge so the first interval is full length.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 24'd1;
        phase_d     = phase_q;
        if (low_time_d && !low_time_q) begin
            blink_cnt_d = 24'd0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_HALF - 24'd1) begin
            blink_cnt_d = 24'd0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            work_q         <= 8'd0;
            last_val_q     <= 8'd0;
            min_acc_q      <= 3'd0;
            tens_acc_q     <= 3'd0;
            first_q        <= 1'b1;
            minutes_q      <= 4'd0;
            sec_tens_q     <= 4'd0;
            sec_ones_q     <= 4'd0;
            digits_valid_q <= 1'b0;
            update_pulse_q <= 1'b0;
            low_time_q     <= 1'b0;
            time_up_q      <= 1'b0;
            blink_cnt_q    <= 24'd0;
            phase_q        <= 1'b1;
        end else begin
            work_q         <= work_d;
            last_val_q     <= last_val_d;
            min_acc_q      <= min_acc_d;
            tens_acc_q     <= tens_acc_d;
            first_q        <= first_d;
            minutes_q      <= minutes_d;
            sec_tens_q     <= sec_tens_d;
            sec_ones_q     <= sec_ones_d;
            digits_valid_q <= digits_valid_d;
            update_pulse_q <= update_pulse_d;
            low_time_q     <= low_time_d;
            time_up_q      <= time_up_d;
            blink_cnt_q    <= blink_cnt_d;
            phase_q        <= phase_d;
        end
    end

endmodule

// File: tb/tb_timer_digit_formatter.sv
// Scoreboard bench for timer_digit_formatter: expected digits are queued when
// a value is driven and compared when update_pulse appears.
module tb_timer_digit_formatter;

    logic       clock;
    logic       reset_n;
    logic [7:0] seconds_in;
    logic       force_update;
    logic [3:0] minutes, sec_tens, sec_ones;
    logic       digits_valid, update_pulse, busy, low_time, time_up, display_on;

    timer_digit_formatter #(
        .LOW_THRESH(8'd30),
        .BLINK_HALF(24'd4)
    ) dut (
        .clock_i        (clock),
        .reset_n_i      (reset_n),
        .seconds_in_i   (seconds_in),
        .force_update_i (force_update),
        .minutes_o      (minutes),
        .sec_tens_o     (sec_tens),
        .sec_ones_o     (sec_ones),
        .digits_valid_o (digits_valid),
        .update_pulse_o (update_pulse),
        .busy_o         (busy),
        .low_time_o     (low_time),
        .time_up_o      (time_up),
        .display_on_o   (display_on)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int v; int m; int t; int o; int low; int tu; int busy_len;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_run = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input int v);
        exp_t e;
        e.v        = v;
        e.m        = v / 60;
        e.t        = (v % 60) / 10;
        e.o        = v % 10;
        e.low      = (v != 0 && v <= 30) ? 1 : 0;
        e.tu       = (v == 0) ? 1 : 0;
        e.busy_len = e.m + e.t + 3;
        return e;
    endfunction

    task automatic push(input int v);
        sb_q.push_back(model(v));
    endtask

    task automatic wait_pulse(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clock);
            if (update_pulse) seen = 1'b1;
        end
        if (!seen) chk("pulse_timeout", 0, 1);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (update_pulse) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("minutes[%0d]", e.v), int'(minutes), e.m);
                    chk($sformatf("sec_tens[%0d]", e.v), int'(sec_tens), e.t);
                    chk($sformatf("sec_ones[%0d]", e.v), int'(sec_ones), e.o);
                    chk($sformatf("low_time[%0d]", e.v), int'(low_time), e.low);
                    chk($sformatf("time_up[%0d]", e.v), int'(time_up), e.tu);
                    chk($sformatf("digits_valid[%0d]", e.v), int'(digits_valid), 1);
                    chk($sformatf("busy_cycles[%0d]", e.v), busy_run, e.busy_len);
                    if (e.low == 0) chk($sformatf("display_solid[%0d]", e.v), int'(display_on), 1);
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        seconds_in   = 8'd150;
        force_update = 1'b0;
        push(150);
        #1;
        chk("rst_minutes", int'(minutes), 0);
        chk("rst_digits_valid", int'(digits_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_display_on", int'(display_on), 1);
        chk("rst_update_pulse", int'(update_pulse), 0);
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clock);

        for (int v = 149; v >= 0; v--) begin
            seconds_in = 8'(v);
            push(v);
            repeat (20) @(negedge clock);
        end

        seconds_in = 8'd255; push(255);
        repeat (20) @(negedge clock);
        seconds_in = 8'd239; push(239);
        repeat (20) @(negedge clock);

        // Blink: full-length first interval starting high, 4 cycles per half.
        seconds_in = 8'd10; push(10);
        wait_pulse(30);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("blink[%0d]", k), int'(display_on), ((k / 4) % 2 == 0) ? 1 : 0);
            @(negedge clock);
        end
        repeat (10) @(negedge clock);

        seconds_in = 8'd0; push(0);
        wait_pulse(30);
        for (int k = 0; k < 8; k++) begin
            chk("timeup_display_solid", int'(display_on), 1);
            @(negedge clock);
        end

        // Value that changes and reverts while busy must not reconvert.
        seconds_in = 8'd100; push(100);
        @(negedge clock);
        chk("busy_started", int'(busy), 1);
        seconds_in = 8'd90;
        @(negedge clock);
        seconds_in = 8'd100;
        repeat (20) @(negedge clock);

        force_update = 1'b1; push(100);
        @(negedge clock);
        force_update = 1'b0;
        repeat (20) @(negedge clock);

        // Held for two cycles: second sample lands in MIN and is dropped.
        force_update = 1'b1; push(100);
        @(negedge clock);
        @(negedge clock);
        force_update = 1'b0;
        repeat (20) @(negedge clock);

        // Asynchronous reset during MIN aborts; first flag reconverts afterwards.
        seconds_in = 8'd239; push(239);
        @(negedge clock);
        @(negedge clock);
        chk("mid_min_busy", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_minutes", int'(minutes), 0);
        chk("async_sec_tens", int'(sec_tens), 0);
        chk("async_sec_ones", int'(sec_ones), 0);
        chk("async_digits_valid", int'(digits_valid), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_time_up", int'(time_up), 0);
        chk("async_display_on", int'(display_on), 1);
        @(negedge clock);
        @(negedge clock);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clock);

        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
